// File: rtl/linear_output_accum.sv
// Recombines MSB-first radix bit-plane partial sums into class scores
// and runs a sequential argmax over the finished scores.
module linear_output_accum #(
  parameter int CHANNELS_OUT = 10,
  parameter int SUM_BITS     = 10,
  parameter int ACT_BITS     = 3,
  parameter int ACC_BITS     = SUM_BITS + ACT_BITS,
  parameter int CH_W         = $clog2(CHANNELS_OUT)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                sum_valid,
  input  logic [SUM_BITS-1:0] sum_data,
  output logic                sum_ready,
  output logic                busy,
  output logic                done,
  output logic [CH_W-1:0]     class_idx,
  output logic [ACC_BITS-1:0] class_score
);

  localparam int PL_W = (ACT_BITS > 1) ? $clog2(ACT_BITS) : 1;
  localparam int EXT  = ACC_BITS - SUM_BITS;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    SCAN,
    DONE
  } state_t;

  state_t state;

  logic signed [ACC_BITS-1:0] acc [CHANNELS_OUT];
  logic signed [ACC_BITS-1:0] best;
  logic [CH_W-1:0]            best_idx;
  logic [CH_W-1:0]            ch_cnt;
  logic [CH_W-1:0]            scan_idx;
  logic [PL_W-1:0]            pl_cnt;

  logic                       xfer;
  logic                       last_ch;
  logic                       last_pl;
  logic                       last_scan;
  logic                       take;
  logic signed [ACC_BITS-1:0] sum_ext;
  logic signed [ACC_BITS-1:0] acc_sel;
  logic signed [ACC_BITS-1:0] acc_next;
  logic signed [ACC_BITS-1:0] scan_val;

  assign sum_ready = (state == ACCUM) && !start;
  assign busy      = (state == ACCUM) || (state == SCAN);
  assign xfer      = sum_valid && sum_ready;

  assign last_ch   = ch_cnt == CH_W'(CHANNELS_OUT - 1);
  assign last_pl   = pl_cnt == PL_W'(ACT_BITS - 1);
  assign last_scan = scan_idx == CH_W'(CHANNELS_OUT - 1);

  assign sum_ext  = {{EXT{sum_data[SUM_BITS-1]}}, sum_data};
  assign acc_sel  = acc[ch_cnt];
  assign acc_next = (acc_sel <<< 1) + sum_ext;

  // Strictly greater keeps the lowest index on ties.
  assign scan_val = acc[scan_idx];
  assign take     = (scan_idx == '0) || (scan_val > best);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      done        <= 1'b0;
      class_idx   <= '0;
      class_score <= '0;
      best        <= '0;
      best_idx    <= '0;
      ch_cnt      <= '0;
      pl_cnt      <= '0;
      scan_idx    <= '0;
      for (int i = 0; i < CHANNELS_OUT; i++) begin
        acc[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      if (start) begin
        state    <= ACCUM;
        best     <= '0;
        best_idx <= '0;
        ch_cnt   <= '0;
        pl_cnt   <= '0;
        scan_idx <= '0;
        for (int i = 0; i < CHANNELS_OUT; i++) begin
          acc[i] <= '0;
        end
      end else begin
        unique case (state)
          IDLE: begin
          end
          ACCUM: begin
            if (xfer) begin
              acc[ch_cnt] <= acc_next;
              if (last_ch) begin
                ch_cnt <= '0;
                if (last_pl) begin
                  pl_cnt   <= '0;
                  scan_idx <= '0;
                  state    <= SCAN;
                end else begin
                  pl_cnt <= pl_cnt + 1'b1;
                end
              end else begin
                ch_cnt <= ch_cnt + 1'b1;
              end
            end
          end
          SCAN: begin
            if (take) begin
              best     <= scan_val;
              best_idx <= scan_idx;
            end
            if (last_scan) begin
              class_idx   <= take ? scan_idx : best_idx;
              class_score <= take ? scan_val : best;
              done        <= 1'b1;
              scan_idx    <= '0;
              state       <= DONE;
            end else begin
              scan_idx <= scan_idx + 1'b1;
            end
          end
          DONE: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_linear_output_accum.sv
// Scoreboard bench for linear_output_accum: driver queues the expected
// argmax per frame, a negedge monitor checks each done pulse.
module tb_linear_output_accum;

  localparam int N  = 10;
  localparam int NS = 30;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        sum_valid = 1'b0;
  logic [9:0]  sum_data = '0;
  logic        sum_ready;
  logic        busy;
  logic        done;
  logic [3:0]  class_idx;
  logic [12:0] class_score;

  linear_output_accum dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .sum_valid   (sum_valid),
    .sum_data    (sum_data),
    .sum_ready   (sum_ready),
    .busy        (busy),
    .done        (done),
    .class_idx   (class_idx),
    .class_score (class_score)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  idx;
    logic [12:0] score;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc = 0;
  logic signed [9:0] fr [NS];

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
               $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && done === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done at %0t", $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("class_idx", 32'(class_idx), 32'(e.idx));
        chk("class_score", 32'(class_score), 32'(e.score));
        chk("done_latency", cyc - last_acc, 32'd10);
        chk("ready_in_done", 32'(sum_ready), 32'd0);
        chk("busy_in_done", 32'(busy), 32'd0);
      end
    end
  end

  task automatic set_all(input logic signed [9:0] v);
    for (int k = 0; k < NS; k++) fr[k] = v;
  endtask

  task automatic set_ch(input int c, input logic signed [9:0] v0,
                        input logic signed [9:0] v1,
                        input logic signed [9:0] v2);
    fr[c]       = v0;
    fr[N + c]   = v1;
    fr[2*N + c] = v2;
  endtask

  task automatic push(input logic [3:0] idx, input logic [12:0] score);
    exp_t e;
    e.idx   = idx;
    e.score = score;
    q.push_back(e);
  endtask

  task automatic pulse_start(input bit junk);
    @(posedge clk);
    #1 start = 1'b1;
    sum_valid = junk;
    sum_data = 10'd200;
    #1 chk("ready_with_start", 32'(sum_ready), 32'd0);
    @(posedge clk);
    #1 start = 1'b0;
    sum_valid = 1'b0;
  endtask

  task automatic send_sums(input int n, input bit bp);
    for (int k = 0; k < n; k++) begin
      if (bp) begin
        while ($urandom_range(1, 0) == 0) begin
          sum_valid = 1'b0;
          @(posedge clk);
          #1;
        end
      end
      sum_valid = 1'b1;
      sum_data = fr[k];
      @(posedge clk);
      #1;
    end
    sum_valid = 1'b0;
  endtask

  task automatic drive_frame(input bit bp, input bit junk);
    pulse_start(junk);
    send_sums(NS, bp);
    last_acc = cyc;
    if (junk) begin
      sum_valid = 1'b1;
      sum_data = 10'h1FF;
    end
    #1 chk("ready_in_scan", 32'(sum_ready), 32'd0);
    chk("busy_in_scan", 32'(busy), 32'd1);
  endtask

  task automatic wait_result();
    for (int i = 0; i < 40 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL result_timeout: %0d results pending", q.size());
      q.delete();
    end
    #1 sum_valid = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ready"}, 32'(sum_ready), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_idx"}, 32'(class_idx), 32'd0);
    chk({tag, "_score"}, 32'(class_score), 32'd0);
  endtask

  task automatic frame_basic();
    set_all(10'sd0);
    set_ch(3, 10'sd1, 10'sd0, 10'sd1);
  endtask

  task automatic frame_signed();
    set_all(-10'sd1);
    set_ch(7, 10'sd0, 10'sd0, -10'sd1);
  endtask

  task automatic frame_tie();
    set_all(10'sd0);
    set_ch(2, 10'sd511, 10'sd511, 10'sd511);
    set_ch(5, 10'sd511, 10'sd511, 10'sd511);
    set_ch(9, -10'sd512, -10'sd512, -10'sd512);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 check_zero("reset");
    rst_n = 1'b1;
    sum_valid = 1'b1;
    #1 chk("ready_idle", 32'(sum_ready), 32'd0);
    sum_valid = 1'b0;

    frame_basic();
    push(4'd3, 13'd5);
    drive_frame(1'b0, 1'b0);
    wait_result();

    frame_signed();
    push(4'd7, 13'h1FFF);
    drive_frame(1'b0, 1'b0);
    wait_result();

    frame_tie();
    push(4'd2, 13'd3577);
    drive_frame(1'b0, 1'b0);
    wait_result();

    frame_tie();
    push(4'd2, 13'd3577);
    drive_frame(1'b1, 1'b1);
    wait_result();

    frame_signed();
    push(4'd7, 13'h1FFF);
    drive_frame(1'b1, 1'b1);
    wait_result();

    repeat (3) @(posedge clk);
    #1 chk("hold_idx", 32'(class_idx), 32'd7);
    chk("hold_score", 32'(class_score), 32'h1FFF);

    set_all(10'sd100);
    pulse_start(1'b0);
    send_sums(15, 1'b0);
    chk("restart_hold_idx", 32'(class_idx), 32'd7);
    chk("restart_hold_score", 32'(class_score), 32'h1FFF);
    frame_basic();
    push(4'd3, 13'd5);
    drive_frame(1'b0, 1'b1);
    wait_result();

    frame_signed();
    drive_frame(1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    check_zero("midscan_reset");
    sum_valid = 1'b1;
    sum_data = 10'sd300;
    repeat (15) @(posedge clk);
    #1 chk("post_reset_ready", 32'(sum_ready), 32'd0);
    chk("post_reset_busy", 32'(busy), 32'd0);
    sum_valid = 1'b0;

    frame_basic();
    push(4'd3, 13'd5);
    drive_frame(1'b0, 1'b0);
    wait_result();

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/linear_output_accum.md
Name: linear_output_accum

Overview:
- Downstream consumer of the final linear layer (CHANNELS_OUT = 10, SUM_BITS = 10, ACT_BITS = 3).
- The linear unit emits one signed partial sum per output channel per radix bit-plane, MSB plane first.
- This block recombines the planes with shift-and-add into full-precision class scores.
- It then runs a sequential argmax and reports the winning class index and score.

Parameters:
- CHANNELS_OUT, 10, number of output classes / channels per bit-plane.
- SUM_BITS, 10, width of signed per-plane partial sum from the linear unit.
- ACT_BITS, 3, number of radix bit-planes per frame.
- ACC_BITS, SUM_BITS+ACT_BITS (13), width of signed score accumulator.
- CH_W, $clog2(CHANNELS_OUT) (4), channel index width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle pulse: clear accumulators, begin new frame.
- sum_valid  in  1  partial sum present on sum_data.
- sum_data  in  SUM_BITS  signed partial sum, two's complement.
- sum_ready  out  1  block accepts sum this cycle.
- busy  out  1  frame in progress (ACCUM or SCAN).
- done  out  1  one-cycle pulse: result valid.
- class_idx  out  CH_W  argmax channel index.
- class_score  out  ACC_BITS  signed score of winning channel.

Behaviour:
- States: IDLE, ACCUM, SCAN, DONE. Reset (rst_n=0 at edge) → IDLE.
- Reset values: sum_ready=0, busy=0, done=0, class_idx=0, class_score=0, all accumulators=0, counters=0.
- Reset mid-frame aborts the frame with no done pulse.

Sum handshake:
- sum_ready = (state==ACCUM) && !start (combinational).
- A transfer occurs on an edge with sum_valid && sum_ready. sum_valid may gap arbitrarily.
- sum_valid while sum_ready=0 is ignored. No state change, no error.

Ordering and accumulation:
- Per plane, sums arrive for channel 0..CHANNELS_OUT-1 in order, tracked by an internal channel counter ch_cnt.
- A plane counter pl_cnt counts 0..ACT_BITS-1.
- On transfer: acc[ch_cnt] ← (acc[ch_cnt] <<< 1) + sign_extend(sum_data). Result truncated to ACC_BITS; no overflow is possible at the default sizing.
- ch_cnt wraps at CHANNELS_OUT-1 → 0 and increments pl_cnt.
- A transfer with ch_cnt=CHANNELS_OUT-1 and pl_cnt=ACT_BITS-1 moves the FSM to SCAN.

start handling:
- In any state, start clears acc[], ch_cnt, pl_cnt and best registers, deasserts done, and enters ACCUM next cycle.
- start has priority over a simultaneous sum (the sum is not accepted).
- class_idx and class_score hold their previous values until the next done.

SCAN:
- One channel compared per cycle, scan index 0..CHANNELS_OUT-1.
- Index 0 loads best=acc[0], best_idx=0.
- Later indices replace best only if acc[i] > best (strictly greater, signed), so ties resolve to the lowest index.
- After comparing index CHANNELS_OUT-1: class_idx/class_score are registered, done=1 for exactly one cycle, state → DONE.
- Latency: done visible CHANNELS_OUT edges after the edge accepting the last sum (10 at defaults).

DONE and IDLE:
- DONE waits for start.
- busy=1 in ACCUM and SCAN only.

Test Plan:
- Basic: start, 3 planes; ch3 sums 1,0,1, all others 0 → acc[3]=5, done after 10 edges, class_idx=3, class_score=5.
- Signed: all channels sum −1 per plane (acc=−7) except ch7 with planes 0,0,−1 (acc=−1) → class_idx=7, class_score=−1 (13'h1FFF).
- Tie and extremes: ch2 and ch5 both 511 each plane → 511·7=3577; ch9 −512 each plane → −3584. Result class_idx=2, class_score=3577; no wrap.
- Backpressure: sum_valid toggled pseudo-randomly (~50%) over 30 transfers → result identical to gap-free run; sum_ready low throughout SCAN/DONE; sums driven then are ignored.
- Restart: start mid plane 1 then a full clean frame → result reflects the new frame only. start coincident with sum_valid → that sum is dropped.
- Reset mid-SCAN: rst_n low one cycle → all outputs 0, state IDLE, no done pulse; sum_ready stays 0 until start.
